// File: rtl/light_pkg.sv
// Shared definitions for the light-sensor chain: FSM states and sizing constants
// used by the PWM stage and the SPI sensor reader.
package light_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    PRIME = 2'd1,
    RUN   = 2'd2
  } light_state_t;

  localparam int SAMPLE_W  = 8;
  localparam int PWM_STEPS = 255;

endpackage

// File: rtl/light_pwm_iir_filter.sv
// First-order IIR smoother: acc tracks data scaled by 2^FILTER_SHIFT, and filt is
// the smoothed 8-bit sample.
module iir_filter
  import light_pkg::*;
#(
  parameter int FILTER_SHIFT = 3
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic                             load,
  input  logic                             update,
  input  logic [SAMPLE_W-1:0]              data,
  output logic [SAMPLE_W+FILTER_SHIFT-1:0] acc,
  output logic [SAMPLE_W-1:0]              filt
);

  localparam int ACC_W = SAMPLE_W + FILTER_SHIFT;

  logic [ACC_W-1:0] acc_next;

  // The sum can wrap before the subtraction, but the final value always fits in
  // ACC_W bits, so modulo arithmetic still gives the exact result.
  assign acc_next = acc + ACC_W'(data) - (acc >> FILTER_SHIFT);
  assign filt     = acc[ACC_W-1:FILTER_SHIFT];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc <= '0;
    end else if (load) begin
      acc <= {data, {FILTER_SHIFT{1'b0}}};
    end else if (update) begin
      acc <= acc_next;
    end
  end

endmodule

// File: rtl/light_pwm.sv
// Ambient-light-driven LED PWM: filters the sensor sample and maps it to a duty
// cycle that is applied only at PWM period boundaries.
module light_pwm
  import light_pkg::*;
#(
  parameter int PRESCALE     = 4,
  parameter int FILTER_SHIFT = 3,
  parameter int INVERT       = 1,
  parameter int MIN_DUTY     = 8
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                enable,
  input  logic [SAMPLE_W-1:0] data,
  output logic                pwm,
  output logic [SAMPLE_W-1:0] duty,
  output logic                period_start
);

  localparam int ACC_W = SAMPLE_W + FILTER_SHIFT;
  localparam int PW    = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [PW-1:0]       PRESC_MAX = PW'(PRESCALE - 1);
  localparam logic [SAMPLE_W-1:0] PHASE_MAX = SAMPLE_W'(PWM_STEPS - 1);

  light_state_t        state, state_next;
  logic [PW-1:0]       presc;
  logic [SAMPLE_W-1:0] phase;
  logic [ACC_W-1:0]    acc;
  logic [SAMPLE_W-1:0] filt;
  logic                tick;
  logic                period_end;

  function automatic logic [SAMPLE_W-1:0] map_duty(input logic [SAMPLE_W-1:0] x);
    logic [SAMPLE_W-1:0] t;
    t = (INVERT != 0) ? (SAMPLE_W'(PWM_STEPS) - x) : x;
    return (t < SAMPLE_W'(MIN_DUTY)) ? '0 : t;
  endfunction

  assign tick         = (state == RUN) && (presc == PRESC_MAX);
  assign period_end   = tick && (phase == PHASE_MAX);
  assign period_start = (state == RUN) && (presc == '0) && (phase == '0);

  iir_filter #(.FILTER_SHIFT(FILTER_SHIFT)) u_filter (
    .clk    (clk),
    .rst_n  (rst_n),
    .load   (state == PRIME),
    .update (period_end),
    .data   (data),
    .acc    (acc),
    .filt   (filt)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    if (!enable) begin
      state_next = IDLE;
    end else begin
      case (state)
        IDLE:    state_next = PRIME;
        PRIME:   state_next = RUN;
        RUN:     state_next = RUN;
        default: state_next = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      presc <= '0;
      phase <= '0;
    end else if (state != RUN) begin
      presc <= '0;
      phase <= '0;
    end else begin
      presc <= tick ? '0 : presc + 1'b1;
      if (tick) begin
        phase <= (phase == PHASE_MAX) ? '0 : phase + 1'b1;
      end
    end
  end

  // filt still holds the pre-update accumulator on the period-end cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      duty <= '0;
      pwm  <= 1'b0;
    end else begin
      if (state == PRIME) begin
        duty <= map_duty(data);
      end else if (period_end) begin
        duty <= map_duty(filt);
      end
      pwm <= (state == RUN) && (phase < duty);
    end
  end

endmodule

// File: doc/light_pwm.md
# light_pwm

Downstream consumer of the light-sensor SPI reader: takes its 8-bit `data` sample, smooths it with a first-order IIR filter, and maps it to a duty cycle. It then drives a glitch-free PWM output for the LED driver. Duty updates happen only at PWM period boundaries, so the output never produces a truncated or runt pulse.

## Interface
Parameters:
- `PRESCALE`, 4: clk cycles per PWM phase tick (≥1).
- `FILTER_SHIFT`, 3: IIR weight 1/2^FILTER_SHIFT (1..7).
- `INVERT`, 1: 1 means darker ambient gives brighter LED (target = 255 − filt); 0 means target = filt.
- `MIN_DUTY`, 8: any target below this value is forced to 0 (LED off).

Ports:
- `clk` in 1: system clock.
- `rst_n` in 1: reset, asynchronous, active-low.
- `enable` in 1: run request, synchronous to clk.
- `data` in 8: sensor sample. It is held stable between sensor updates and has no strobe.
- `pwm` out 1: registered PWM output.
- `duty` out 8: duty currently applied.
- `period_start` out 1: one-cycle pulse at the first clk of each PWM period.

## Operation
- The FSM has three states: IDLE, PRIME, RUN. Reset puts it in IDLE.
- IDLE:
  - Prescaler and phase are held at 0; `pwm`=0; `duty` and the filter accumulator hold their values.
  - When `enable`=1, go to PRIME.
- PRIME (one cycle):
  - Load acc ← data << FILTER_SHIFT.
  - Load duty ← map(data).
  - Go to RUN; prescaler and phase are 0.
- RUN:
  - The prescaler counts 0..PRESCALE−1 and `tick` asserts when it equals PRESCALE−1.
  - Phase advances 0..254 on each tick and wraps 254→0. A period is 255 ticks, i.e. 255·PRESCALE clk cycles.
  - Period end is the cycle where tick=1 and phase=254. On that cycle:
    - acc ← acc + data − (acc >> FILTER_SHIFT).
    - duty ← map(acc >> FILTER_SHIFT), using the pre-update acc.
- `enable`=0 in any state: go to IDLE on the next edge. Re-enabling passes through PRIME again, which re-primes the filter.
- Accumulator:
  - Width is 8+FILTER_SHIFT bits, unsigned.
  - The update cannot overflow, because acc ≤ 255·2^FILTER_SHIFT is invariant.
  - filt = acc >> FILTER_SHIFT, 8 bits.
- map(x):
  - t = INVERT ? 255−x : x.
  - Result is 0 if t < MIN_DUTY, else t.
- PWM compare: `pwm` ← (state==RUN) && (phase < duty).
  - duty=0 gives constant low.
  - duty=255 gives constant high for the whole RUN period (phase max is 254).
- `period_start` = (state==RUN) && prescaler==0 && phase==0. It also fires on the first RUN cycle after PRIME.

## Timing
- Reset values:
  - State IDLE; acc=0; prescaler=0; phase=0.
  - `duty`=0, `pwm`=0, `period_start`=0.
- Compare latency: `pwm` is registered, so it lags the phase/duty compare by 1 clk. High time per period is duty·PRESCALE clk cycles.
- Sample-to-duty latency:
  - A sample taken at period end k affects `duty` at period end k+1.
  - The new duty is visible in `pwm` from the first clk of period k+2 plus 1 clk.
- `duty` changes only at period end or in PRIME. It never changes mid-period.
- `enable` falls mid-period: `pwm`=0 from the edge after the IDLE entry (≤2 clk). No `period_start` is asserted while not in RUN.
- `data` changes on the period-end cycle: the value present at that clk edge is used.
- Asynchronous reset mid-RUN: all registers return to reset values immediately; `pwm` drops without waiting for the clock.

## Structure
- Shared package `light_pkg`:
  - FSM state encoding (IDLE/PRIME/RUN).
  - `PWM_STEPS`=255 and the 8-bit sample width constant, also reused by the sensor reader.
- One sub-module, `iir_filter`:
  - Inputs: load, update, 8-bit data.
  - Outputs: acc and filt.
  - Parameterised by FILTER_SHIFT.
- Prescaler, phase counter, FSM and map/compare logic stay in `light_pwm`.

## Test plan
All scenarios use PRESCALE=4, FILTER_SHIFT=3, INVERT=1, MIN_DUTY=8; the period is 1020 clk.
- Reset with `enable`=0 → `pwm`=0, `duty`=0, `period_start`=0, no toggling for 2000 clk.
- `enable`=1, `data`=0x40 → PRIME: acc=0x200, `duty`=0xBF. `period_start` every 1020 clk; `pwm` high 764 clk, low 256 clk per period.
- Step `data` 0x40→0xC0 in RUN → `duty` sequence 0xBF, 0xBF, 0xAF (filt 0x50), 0xA1 (acc 0x2F0, filt 0x5E), … monotonically decreasing toward 0x3F, one change per period, each change aligned to `period_start`.
- MIN_DUTY and extremes:
  - `data`=0xFC (t=0x03) → `duty`=0, `pwm` never high.
  - `data`=0xF8 (t=0x07) → `duty`=0.
  - `data`=0xF7 (t=0x08) → `duty`=0x08.
  - Re-prime with `data`=0x00 → `duty`=0xFF, `pwm` constant high.
- Drop `enable` at phase 100 → `pwm`=0 within 2 clk and `duty` holds. Re-enable with `data`=0x80 → PRIME reloads acc=0x400 and `duty`=0x7F.
- Assert `rst_n`=0 asynchronously mid-high-pulse → `pwm`, `duty`, `period_start` go to 0 before the next clk edge. Release → IDLE.
